matmul_scheduler: RTL and testbench

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

---
 rtl/matmul_scheduler_pkg.sv | 30 +++
 rtl/matmul_scheduler_if.sv | 28 ++
 rtl/rr_pick2.sv | 15 +
 rtl/matmul_scheduler.sv | 121 ++++++++++++
 tb/tb_matmul_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_scheduler_pkg.sv
// Shared types, defaults and the operand-dimension check for the matmul scheduler.
package matmul_scheduler_pkg;

    localparam int unsigned MaxDimDefault       = 5;
    localparam int unsigned StartTimeoutDefault = 4;
    localparam int unsigned RunTimeoutDefault   = 32;

    localparam int unsigned CntWidth = 6;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StRun     = 3'd2,
        StDone    = 3'd3,
        StError   = 3'd4,
        StRelease = 3'd5
    } state_e;

    // A job is legal when every dimension is 1..max_dim and the inner dimensions agree.
    function automatic logic dims_ok(logic [2:0] r1, logic [2:0] c1, logic [2:0] r2,
                                     logic [2:0] c2, int unsigned max_dim);
        logic ok;
        ok = (r1 != 3'd0) && (c1 != 3'd0) && (r2 != 3'd0) && (c2 != 3'd0);
        ok = ok && (32'(r1) <= max_dim) && (32'(c1) <= max_dim);
        ok = ok && (32'(r2) <= max_dim) && (32'(c2) <= max_dim);
        ok = ok && (c1 == r2);
        return ok;
    endfunction

endpackage

// File: rtl/matmul_scheduler_if.sv
// Requester, multiplier and status signals of the matmul scheduler.
interface matmul_scheduler_if;

    logic [1:0] req;
    logic [2:0] r1_0, c1_0, r2_0, c2_0;
    logic [2:0] r1_1, c1_1, r2_1, c2_1;
    logic       mult_busy;
    logic       mult_valid;
    logic       mult_en;
    logic       sel;
    logic [1:0] grant;
    logic [1:0] done;
    logic [1:0] err;
    logic [2:0] state_dbg;

    // Scheduler side.
    modport master (
        input  req, r1_0, c1_0, r2_0, c2_0, r1_1, c1_1, r2_1, c2_1, mult_busy, mult_valid,
        output mult_en, sel, grant, done, err, state_dbg
    );

    // Requester / multiplier side.
    modport slave (
        output req, r1_0, c1_0, r2_0, c2_0, r1_1, c1_1, r2_1, c2_1, mult_busy, mult_valid,
        input  mult_en, sel, grant, done, err, state_dbg
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       pick,
    output logic       any
);

    // Requester 1 wins when it is alone or when requester 1 was not the last one served.
    always_comb begin
        any  = |req;
        pick = req[1] & (~req[0] | ~last_served);
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Arbitrates two requesters onto one shared matrix multiplier and supervises each job.
module matmul_scheduler
    import matmul_scheduler_pkg::*;
#(
    parameter int unsigned MAX_DIM       = MaxDimDefault,
    parameter int unsigned START_TIMEOUT = StartTimeoutDefault,
    parameter int unsigned RUN_TIMEOUT   = RunTimeoutDefault
) (
    input logic                clk,
    input logic                reset_n,
    matmul_scheduler_if.master bus
);

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic                  mult_en_q, mult_en_d;

    logic                  pick;
    logic                  any;
    logic [2:0]            pr1, pc1, pr2, pc2;
    logic                  req_sel;
    logic                  start_expired;
    logic                  run_expired;
    logic [1:0]            sel_oh;

    rr_pick2 u_pick (
        .req         (bus.req),
        .last_served (last_q),
        .pick        (pick),
        .any         (any)
    );

    assign pr1     = pick ? bus.r1_1 : bus.r1_0;
    assign pc1     = pick ? bus.c1_1 : bus.c1_0;
    assign pr2     = pick ? bus.r2_1 : bus.r2_0;
    assign pc2     = pick ? bus.c2_1 : bus.c2_0;
    assign req_sel = bus.req[sel_q];

    // cnt_q counts completed cycles in the current state, so the last allowed cycle is N-1.
    assign start_expired = 32'(cnt_q) >= START_TIMEOUT - 1;
    assign run_expired   = 32'(cnt_q) >= RUN_TIMEOUT - 1;

    // Next-state selection plus registered-output values derived from the next state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    sel_d   = pick;
                    state_d = dims_ok(pr1, pc1, pr2, pc2, MAX_DIM) ? StStart : StError;
                end
            end
            StStart: begin
                if (!req_sel)           state_d = StRelease;
                else if (bus.mult_busy) state_d = StRun;
                else if (!bus.mult_valid || start_expired) state_d = StError;
            end
            StRun: begin
                if (!req_sel)            state_d = StRelease;
                else if (!bus.mult_busy) state_d = StDone;
                else if (run_expired)    state_d = StError;
            end
            StDone, StError: begin
                if (!req_sel) state_d = StRelease;
            end
            StRelease: begin
                last_d  = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        cnt_d = (state_d != state_q) ? '0 :
                (&cnt_q)             ? cnt_q : cnt_q + 1'b1;

        sel_oh    = sel_d ? 2'b10 : 2'b01;
        mult_en_d = (state_d == StStart) || (state_d == StRun) || (state_d == StDone);
        grant_d   = (state_d == StStart) || (state_d == StRun) || (state_d == StDone) ||
                    (state_d == StError) ? sel_oh : 2'b00;
        done_d    = (state_d == StDone)  ? sel_oh : 2'b00;
        err_d     = (state_d == StError) ? sel_oh : 2'b00;
    end

    // State and output registers; reset drops mult_en immediately to clear the multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            grant_q   <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            mult_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mult_en_q <= mult_en_d;
        end
    end

    assign bus.mult_en   = mult_en_q;
    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a small behavioural multiplier model.
module tb_matmul_scheduler;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_miss;
    int   busy_len;
    logic valid_cfg;
    logic m_busy;
    logic m_started;
    int   m_left;
    int   cyc;
    int   en_low;

    matmul_scheduler_if bus_if ();

    matmul_scheduler #(
        .MAX_DIM       (5),
        .START_TIMEOUT (4),
        .RUN_TIMEOUT   (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: once enabled, raises busy for busy_len cycles; disable clears it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy    <= 1'b0;
            m_started <= 1'b0;
            m_left    <= 0;
        end else if (!bus_if.mult_en) begin
            m_busy    <= 1'b0;
            m_started <= 1'b0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            if (busy_len > 0) begin
                m_busy <= 1'b1;
                m_left <= busy_len;
            end
        end else if (m_busy) begin
            if (m_left <= 1) m_busy <= 1'b0;
            else             m_left <= m_left - 1;
        end
    end

    assign bus_if.mult_busy  = m_busy;
    assign bus_if.mult_valid = bus_if.mult_en & valid_cfg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dims(input logic who, input logic [2:0] r1, input logic [2:0] c1,
                            input logic [2:0] r2, input logic [2:0] c2);
        if (who) begin
            bus_if.r1_1 = r1; bus_if.c1_1 = c1; bus_if.r2_1 = r2; bus_if.c2_1 = c2;
        end else begin
            bus_if.r1_0 = r1; bus_if.c1_0 = c1; bus_if.r2_0 = r2; bus_if.c2_0 = c2;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cycles, output int cycles);
        cycles = 0;
        while (bus_if.state_dbg != st && cycles < max_cycles) begin
            step();
            cycles++;
        end
    endtask

    task automatic finish_job();
        bus_if.req = 2'b00;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_miss = 0;
        reset_n = 1'b0; busy_len = 0; valid_cfg = 1'b1;
        bus_if.req = 2'b00;
        set_dims(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        set_dims(1'b1, 3'd0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus_if.state_dbg), 32'(S_IDLE));
        check("rst_en",    32'(bus_if.mult_en), 0);
        check("rst_sel",   32'(bus_if.sel), 0);
        check("rst_grant", 32'(bus_if.grant), 0);
        check("rst_done",  32'(bus_if.done), 0);
        check("rst_err",   32'(bus_if.err), 0);
        reset_n = 1'b1;
        step();

        // Normal job: 3x4 * 4x2, busy for 25 cycles.
        set_dims(1'b0, 3'd3, 3'd4, 3'd4, 3'd2);
        busy_len = 25;
        bus_if.req = 2'b01;
        step();
        check("a_start", 32'(bus_if.state_dbg), 32'(S_START));
        check("a_grant", 32'(bus_if.grant), 1);
        check("a_en",    32'(bus_if.mult_en), 1);
        step();
        step();
        check("a_run", 32'(bus_if.state_dbg), 32'(S_RUN));
        en_low = 0; cyc = 0;
        while (bus_if.state_dbg == S_RUN && cyc < 60) begin
            if (!bus_if.mult_en) en_low++;
            step();
            cyc++;
        end
        check("a_run_len",  32'(cyc), 25);
        check("a_en_run",   32'(en_low), 0);
        check("a_done",     32'(bus_if.done), 1);
        check("a_err",      32'(bus_if.err), 0);
        check("a_en_done",  32'(bus_if.mult_en), 1);
        bus_if.req = 2'b00;
        step();
        check("a_release",  32'(bus_if.state_dbg), 32'(S_RELEASE));
        check("a_rel_en",   32'(bus_if.mult_en), 0);
        check("a_rel_done", 32'(bus_if.done), 0);
        check("a_rel_grant", 32'(bus_if.grant), 0);
        step();
        check("a_idle", 32'(bus_if.state_dbg), 32'(S_IDLE));

        // Tie right after reset: requester 0 first, then requester 1.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        set_dims(1'b0, 3'd2, 3'd2, 3'd2, 3'd2);
        set_dims(1'b1, 3'd2, 3'd3, 3'd3, 3'd4);
        busy_len = 3;
        bus_if.req = 2'b11;
        step();
        check("b_grant0", 32'(bus_if.grant), 1);
        check("b_sel0",   32'(bus_if.sel), 0);
        wait_state(S_DONE, 20, cyc);
        check("b_done0",  32'(bus_if.done), 1);
        check("b_hold0",  32'(bus_if.grant), 1);
        bus_if.req = 2'b10;
        step();
        check("b_release", 32'(bus_if.state_dbg), 32'(S_RELEASE));
        step();
        check("b_idle",    32'(bus_if.state_dbg), 32'(S_IDLE));
        check("b_idle_en", 32'(bus_if.mult_en), 0);
        step();
        check("b_grant1", 32'(bus_if.grant), 2);
        check("b_sel1",   32'(bus_if.sel), 1);
        check("b_start1", 32'(bus_if.state_dbg), 32'(S_START));
        wait_state(S_DONE, 20, cyc);
        check("b_done1",  32'(bus_if.done), 2);
        finish_job();

        // Inner-dimension mismatch on requester 1.
        set_dims(1'b1, 3'd2, 3'd3, 3'd2, 3'd2);
        bus_if.req = 2'b10;
        step();
        check("c_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        check("c_err",   32'(bus_if.err), 2);
        check("c_en",    32'(bus_if.mult_en), 0);
        check("c_done",  32'(bus_if.done), 0);
        bus_if.req = 2'b00;
        step();
        check("c_release", 32'(bus_if.state_dbg), 32'(S_RELEASE));
        step();

        // Dimension above MAX_DIM, then a zero dimension.
        set_dims(1'b0, 3'd6, 3'd2, 3'd2, 3'd2);
        bus_if.req = 2'b01;
        step();
        check("c_big_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        check("c_big_err",   32'(bus_if.err), 1);
        finish_job();
        set_dims(1'b0, 3'd2, 3'd2, 3'd2, 3'd0);
        bus_if.req = 2'b01;
        step();
        check("c_zero_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        finish_job();

        // Largest legal dims start; dropping req in START aborts without done.
        set_dims(1'b0, 3'd5, 3'd5, 3'd5, 3'd5);
        busy_len = 0;
        bus_if.req = 2'b01;
        step();
        check("c_max_state", 32'(bus_if.state_dbg), 32'(S_START));
        bus_if.req = 2'b00;
        step();
        check("c_abort_state", 32'(bus_if.state_dbg), 32'(S_RELEASE));
        check("c_abort_done",  32'(bus_if.done), 0);
        step();

        // Multiplier never reacts: START timeout after 4 cycles.
        set_dims(1'b0, 3'd3, 3'd4, 3'd4, 3'd2);
        busy_len = 0;
        bus_if.req = 2'b01;
        step();
        repeat (3) step();
        check("d_still_start", 32'(bus_if.state_dbg), 32'(S_START));
        step();
        check("d_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        check("d_err",   32'(bus_if.err), 1);
        check("d_en",    32'(bus_if.mult_en), 0);
        finish_job();

        // mult_valid low in START goes straight to ERROR.
        valid_cfg = 1'b0;
        busy_len = 3;
        bus_if.req = 2'b01;
        step();
        step();
        check("e_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        valid_cfg = 1'b1;
        finish_job();

        // Busy for 40 cycles: RUN watchdog fires at RUN cycle 32.
        busy_len = 40;
        bus_if.req = 2'b01;
        repeat (3) step();
        check("f_run", 32'(bus_if.state_dbg), 32'(S_RUN));
        repeat (31) step();
        check("f_still_run", 32'(bus_if.state_dbg), 32'(S_RUN));
        check("f_en_run",    32'(bus_if.mult_en), 1);
        step();
        check("f_state", 32'(bus_if.state_dbg), 32'(S_ERROR));
        check("f_en",    32'(bus_if.mult_en), 0);
        check("f_err",   32'(bus_if.err), 1);
        finish_job();

        // Asynchronous reset during RUN, then the held request is served again.
        set_dims(1'b1, 3'd2, 3'd2, 3'd2, 3'd2);
        busy_len = 25;
        bus_if.req = 2'b10;
        repeat (3) step();
        check("g_run", 32'(bus_if.state_dbg), 32'(S_RUN));
        reset_n = 1'b0;
        #1;
        check("g_rst_state", 32'(bus_if.state_dbg), 32'(S_IDLE));
        check("g_rst_en",    32'(bus_if.mult_en), 0);
        check("g_rst_grant", 32'(bus_if.grant), 0);
        check("g_rst_sel",   32'(bus_if.sel), 0);
        #1;
        reset_n = 1'b1;
        step();
        check("g_regrant", 32'(bus_if.grant), 2);
        check("g_resel",   32'(bus_if.sel), 1);
        step();
        step();
        check("g_rerun", 32'(bus_if.state_dbg), 32'(S_RUN));
        bus_if.req = 2'b00;
        step();
        check("g_abort_state", 32'(bus_if.state_dbg), 32'(S_RELEASE));
        check("g_abort_done",  32'(bus_if.done), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
